data_mem_uart_tx: RTL and testbench

- Read-out path for the multicore processor system. Once the processor has finished, this block drains a range of DATA_RAM and transmits it over a UART TX line, so the host can collect the results of the matrix multiplication.
- It is the transmit counterpart of the UART loader, which receives bytes and writes them into the memories.
- It sits beside the top-level memory mux. While the top-level FSM is in its read-out state, it owns the DATA_RAM address. It never writes memory.

---
 rtl/data_mem_uart_tx_pkg.sv | 30 +++
 rtl/data_mem_uart_tx_uart_tx_byte.sv | 70 +++++++
 rtl/data_mem_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_data_mem_uart_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_uart_tx_pkg
// Description : Shared FSM encoding, UART frame constants and word-size helper
//               for the DATA_RAM read-out transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;

    function automatic int bytes_per_word(input int width);
        return (width + DATA_BITS - 1) / DATA_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_uart_tx_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 UART byte transmitter, LSB first, idle high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import data_mem_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txStart,
    input  logic [7:0] txByte,
    output logic       tx,
    output logic       txBusy,
    output logic       txDone
);

    localparam int                  c_BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [3:0]          c_LAST_BIT  = 4'(FRAME_BITS - 1);

    logic [c_BAUD_W-1:0] r_baudCnt;
    logic [3:0]          r_bitCnt;
    logic [DATA_BITS:0]  r_shift;
    logic                r_tx;
    logic                r_busy;
    logic                w_bitEnd;

    assign w_bitEnd = r_busy && (r_baudCnt == c_BAUD_LAST);
    assign txDone   = w_bitEnd && (r_bitCnt == c_LAST_BIT);
    assign txBusy   = r_busy;
    assign tx       = r_tx;

    // r_shift holds the bits still to go, with the stop bit parked at the top
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '1;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
        end else if (!r_busy) begin
            if (txStart) begin
                r_busy    <= 1'b1;
                r_baudCnt <= '0;
                r_bitCnt  <= '0;
                r_shift   <= {STOP_BIT, txByte};
                r_tx      <= START_BIT;
            end
        end else if (w_bitEnd) begin
            r_baudCnt <= '0;
            if (r_bitCnt == c_LAST_BIT) begin
                r_busy <= 1'b0;
                r_tx   <= STOP_BIT;
            end else begin
                r_bitCnt <= r_bitCnt + 4'd1;
                r_tx     <= r_shift[0];
                r_shift  <= {STOP_BIT, r_shift[DATA_BITS:1]};
            end
        end else begin
            r_baudCnt <= r_baudCnt + c_BAUD_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_uart_tx
// Description : Drains a DATA_RAM address range and sends each word, byte 0
//               first, over an 8N1 UART line.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_uart_tx
    import data_mem_uart_tx_pkg::*;
#(
    parameter int DATA_MEM_WIDTH      = 12,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int START_ADDR          = 0,
    parameter int WORD_COUNT          = 4096,
    parameter int BAUD_DIV            = 434
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           startN,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] dataMemAddr,
    input  logic [DATA_MEM_WIDTH-1:0]      dataMemRdData,
    output logic                           tx,
    output logic                           ready,
    output logic                           done
);

    localparam int c_BYTES  = bytes_per_word(DATA_MEM_WIDTH);
    localparam int c_WORD_W = c_BYTES * DATA_BITS;
    localparam int c_IDX_W  = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_CNT_W  = $clog2(WORD_COUNT + 1);

    localparam logic [c_IDX_W-1:0]             c_IDX_LAST = c_IDX_W'(c_BYTES - 1);
    localparam logic [c_IDX_W-1:0]             c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_CNT_W-1:0]             c_CNT_LAST = c_CNT_W'(WORD_COUNT - 1);
    localparam logic [c_CNT_W-1:0]             c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [DATA_MEM_ADDR_WIDTH-1:0] c_START    = DATA_MEM_ADDR_WIDTH'(START_ADDR);
    localparam logic [DATA_MEM_ADDR_WIDTH-1:0] c_ADDR_ONE = DATA_MEM_ADDR_WIDTH'(1);

    state_t                         r_state;
    state_t                         w_stateNext;
    logic [DATA_MEM_ADDR_WIDTH-1:0] r_addr;
    logic [c_CNT_W-1:0]             r_wordCnt;
    logic [c_IDX_W-1:0]             r_byteIdx;
    logic [c_WORD_W-1:0]            r_word;

    logic w_txStart;
    logic w_txBusy;
    logic w_txDone;
    logic w_clrRun;
    logic w_latch;
    logic w_advByte;
    logic w_advWord;
    logic w_ready;
    logic w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_txStart   = 1'b0;
        w_clrRun    = 1'b0;
        w_latch     = 1'b0;
        w_advByte   = 1'b0;
        w_advWord   = 1'b0;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (!startN) begin
                    w_clrRun    = 1'b1;
                    w_stateNext = ST_FETCH;
                end
            end
            ST_FETCH: w_stateNext = ST_LATCH;
            ST_LATCH: begin
                w_latch     = 1'b1;
                w_stateNext = ST_SEND;
            end
            ST_SEND: begin
                w_txStart = 1'b1;
                if (!w_txBusy) begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_txDone) begin
                    if (r_byteIdx != c_IDX_LAST) begin
                        w_advByte   = 1'b1;
                        w_stateNext = ST_SEND;
                    end else begin
                        w_stateNext = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                w_advWord   = 1'b1;
                w_stateNext = (r_wordCnt == c_CNT_LAST) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                w_ready = 1'b1;
                w_done  = 1'b1;
                if (!startN) begin
                    w_clrRun    = 1'b1;
                    w_stateNext = ST_FETCH;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Word is zero-extended on capture and shifted down so byte 0 is always at [7:0]
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= c_START;
            r_wordCnt <= '0;
            r_byteIdx <= '0;
            r_word    <= '0;
        end else begin
            if (w_clrRun) begin
                r_addr    <= c_START;
                r_wordCnt <= '0;
            end
            if (w_latch) begin
                r_word    <= c_WORD_W'(dataMemRdData);
                r_byteIdx <= '0;
            end
            if (w_advByte) begin
                r_byteIdx <= r_byteIdx + c_IDX_ONE;
                r_word    <= r_word >> DATA_BITS;
            end
            if (w_advWord) begin
                r_addr    <= r_addr + c_ADDR_ONE;
                r_wordCnt <= r_wordCnt + c_CNT_ONE;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx_byte (
        .clk     (clk),
        .rst     (rst),
        .txStart (w_txStart),
        .txByte  (r_word[7:0]),
        .tx      (tx),
        .txBusy  (w_txBusy),
        .txDone  (w_txDone)
    );

    assign dataMemAddr = r_addr;
    assign ready       = w_ready;
    assign done        = w_done;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_uart_tx
// Description : Scoreboard bench for data_mem_uart_tx; three configurations
//               share one clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_uart_tx;

    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    typedef struct {
        logic [7:0] b;
        int         startCyc;
        int         cut;
        bit         chkAddr;
        int         addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        startN0 = 1'b1, startN1 = 1'b1, startN2 = 1'b1;
    logic [11:0] addr0, addr1, addr2;
    logic [11:0] rd0, rd1;
    logic [23:0] rd2;
    logic        tx0, tx1, tx2, ready0, ready1, ready2, done0, done1, done2;
    logic [11:0] mem0 [0:4095];
    logic [11:0] mem1 [0:4095];
    logic [23:0] mem2 [0:4095];
    logic [11:0] ah0 [0:255];
    logic [11:0] ah1 [0:255];
    logic [11:0] ah2 [0:255];
    logic [7:0]  expBytes [0:7];
    exp_t        q0[$], q1[$], q2[$];

    always @(posedge clk) begin
        rd0 <= mem0[addr0];
        rd1 <= mem1[addr1];
        rd2 <= mem2[addr2];
    end

    always @(negedge clk) begin
        ah0[cyc % 256] <= addr0;
        ah1[cyc % 256] <= addr1;
        ah2[cyc % 256] <= addr2;
    end

    data_mem_uart_tx #(.DATA_MEM_WIDTH(12), .DATA_MEM_ADDR_WIDTH(12), .START_ADDR(0),
                       .WORD_COUNT(2), .BAUD_DIV(BAUD)) dut0 (
        .clk(clk), .rst(rst), .startN(startN0), .dataMemAddr(addr0),
        .dataMemRdData(rd0), .tx(tx0), .ready(ready0), .done(done0));

    data_mem_uart_tx #(.DATA_MEM_WIDTH(12), .DATA_MEM_ADDR_WIDTH(12), .START_ADDR(4094),
                       .WORD_COUNT(3), .BAUD_DIV(BAUD)) dut1 (
        .clk(clk), .rst(rst), .startN(startN1), .dataMemAddr(addr1),
        .dataMemRdData(rd1), .tx(tx1), .ready(ready1), .done(done1));

    data_mem_uart_tx #(.DATA_MEM_WIDTH(24), .DATA_MEM_ADDR_WIDTH(12), .START_ADDR(0),
                       .WORD_COUNT(1), .BAUD_DIV(BAUD)) dut2 (
        .clk(clk), .rst(rst), .startN(startN2), .dataMemAddr(addr2),
        .dataMemRdData(rd2), .tx(tx2), .ready(ready2), .done(done2));

    function automatic logic txOf(input int k);
        return (k == 0) ? tx0 : (k == 1) ? tx1 : tx2;
    endfunction
    function automatic logic doneOf(input int k);
        return (k == 0) ? done0 : (k == 1) ? done1 : done2;
    endfunction
    function automatic logic readyOf(input int k);
        return (k == 0) ? ready0 : (k == 1) ? ready1 : ready2;
    endfunction
    function automatic logic [11:0] addrOf(input int k);
        return (k == 0) ? addr0 : (k == 1) ? addr1 : addr2;
    endfunction
    function automatic logic [11:0] addrBack(input int k, input int c);
        return (k == 0) ? ah0[c % 256] : (k == 1) ? ah1[c % 256] : ah2[c % 256];
    endfunction
    function automatic int qSize(input int k);
        return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pushExp(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic popExp(input int k, output bit got, output exp_t e);
        got = (qSize(k) != 0);
        if (got) begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    // Ideal 8N1 line waveform for one byte, one sample per clock
    function automatic logic [FRAME-1:0] framePat(input logic [7:0] b);
        logic [FRAME-1:0] p;
        logic bv;
        for (int bi = 0; bi < 10; bi++) begin
            bv = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            for (int j = 0; j < BAUD; j++) p[bi*BAUD + j] = bv;
        end
        return p;
    endfunction

    task automatic uartMon(input int k);
        exp_t             e;
        bit               got;
        int               s;
        int               n;
        logic [FRAME-1:0] smp;
        logic [FRAME-1:0] mask;
        logic             idleOk;
        forever begin
            @(negedge clk);
            if (txOf(k) === 1'b0) begin
                s = cyc;
                popExp(k, got, e);
                if (!got) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpected_frame dut%0d at cycle %0d: got start bit, expected idle line", k, s);
                    repeat (FRAME - 1) @(negedge clk);
                end else begin
                    n      = (e.cut > 0) ? e.cut : FRAME;
                    smp    = '1;
                    mask   = '0;
                    smp[0] = 1'b0;
                    mask[0] = 1'b1;
                    for (int i = 1; i < n; i++) begin
                        @(negedge clk);
                        smp[i]  = txOf(k);
                        mask[i] = 1'b1;
                    end
                    check($sformatf("frame_bits dut%0d byte %02h", k, e.b), smp & mask, framePat(e.b) & mask);
                    check($sformatf("frame_start dut%0d byte %02h", k, e.b), s, e.startCyc);
                    if (e.chkAddr)
                        check($sformatf("fetch_addr dut%0d", k), addrBack(k, s - 3), e.addr);
                    if (e.cut > 0) begin
                        idleOk = 1'b1;
                        for (int i = 0; i < FRAME; i++) begin
                            @(negedge clk);
                            if (txOf(k) !== 1'b1) idleOk = 1'b0;
                        end
                        check($sformatf("idle_after_abort dut%0d", k), idleOk, 1'b1);
                    end
                end
            end
        end
    endtask

    initial uartMon(0);
    initial uartMon(1);
    initial uartMon(2);

    // Expected frames of one run starting from edge e0; frame cutFrame is cut after cutLen samples
    task automatic pushRun(input int k, input int e0, input int nWords, input int nBytes,
                           input int startAddr, input int cutFrame, input int cutLen,
                           output int lastS);
        exp_t e;
        int   s;
        int   idx;
        s = e0 + 3;
        for (int w = 0; w < nWords; w++) begin
            for (int b = 0; b < nBytes; b++) begin
                idx = w * nBytes + b;
                if (idx > cutFrame && cutFrame >= 0) break;
                if (idx > 0) s += (b == 0) ? FRAME + 4 : FRAME + 1;
                e.b        = expBytes[idx];
                e.startCyc = s;
                e.cut      = (idx == cutFrame) ? cutLen : 0;
                e.chkAddr  = (b == 0);
                e.addr     = (startAddr + w) % 4096;
                pushExp(k, e);
            end
        end
        lastS = s;
    endtask

    task automatic setStartN(input int k, input logic v);
        case (k)
            0: startN0 = v;
            1: startN1 = v;
            default: startN2 = v;
        endcase
    endtask

    task automatic pulseStart(input int k);
        setStartN(k, 1'b0);
        @(negedge clk);
        setStartN(k, 1'b1);
    endtask

    task automatic checkDone(input int k, input int lastS);
        while (cyc < lastS + FRAME) @(negedge clk);
        check($sformatf("done_in_next dut%0d", k), doneOf(k), 1'b0);
        @(negedge clk);
        check($sformatf("done_rise dut%0d", k), doneOf(k), 1'b1);
        check($sformatf("ready_done dut%0d", k), readyOf(k), 1'b1);
    endtask

    task automatic checkIdle(input int k, input logic [11:0] a);
        check($sformatf("idle_tx dut%0d", k), txOf(k), 1'b1);
        check($sformatf("idle_ready dut%0d", k), readyOf(k), 1'b1);
        check($sformatf("idle_done dut%0d", k), doneOf(k), 1'b0);
        check($sformatf("idle_addr dut%0d", k), addrOf(k), a);
    endtask

    initial begin
        int lastS;
        int e0;
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
            mem2[i] = '0;
        end
        mem0[0]    = 12'hA5C;
        mem0[1]    = 12'h3F1;
        mem1[4094] = 12'h123;
        mem1[4095] = 12'h456;
        mem1[0]    = 12'h789;
        mem2[0]    = 24'h123456;

        // Reset and quiet line
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkIdle(0, 12'd0);
        checkIdle(1, 12'd4094);
        checkIdle(2, 12'd0);
        repeat (100) @(negedge clk);
        checkIdle(0, 12'd0);

        // Two-word dump
        expBytes[0] = 8'h5C; expBytes[1] = 8'h0A; expBytes[2] = 8'hF1; expBytes[3] = 8'h03;
        pushRun(0, cyc + 1, 2, 2, 0, -1, 0, lastS);
        pulseStart(0);
        checkDone(0, lastS);

        // startN held low for the whole run: one run only
        repeat (10) @(negedge clk);
        pushRun(0, cyc + 1, 2, 2, 0, -1, 0, lastS);
        startN0 = 1'b0;
        while (cyc < lastS) @(negedge clk);
        startN0 = 1'b1;
        checkDone(0, lastS);
        repeat (60) @(negedge clk);
        check("no_extra_frames dut0", qSize(0), 0);
        check("still_done dut0", done0, 1'b1);

        // Restart from DONE repeats the stream from address 0
        pushRun(0, cyc + 1, 2, 2, 0, -1, 0, lastS);
        pulseStart(0);
        checkDone(0, lastS);

        // Wrap-around past the top of memory
        expBytes[0] = 8'h23; expBytes[1] = 8'h01; expBytes[2] = 8'h56;
        expBytes[3] = 8'h04; expBytes[4] = 8'h89; expBytes[5] = 8'h07;
        repeat (5) @(negedge clk);
        pushRun(1, cyc + 1, 3, 2, 4094, -1, 0, lastS);
        pulseStart(1);
        checkDone(1, lastS);

        // 24-bit word, three bytes
        expBytes[0] = 8'h56; expBytes[1] = 8'h34; expBytes[2] = 8'h12;
        repeat (5) @(negedge clk);
        pushRun(2, cyc + 1, 1, 3, 0, -1, 0, lastS);
        pulseStart(2);
        checkDone(2, lastS);

        // Reset during data bit 3 of the second frame
        expBytes[0] = 8'h5C; expBytes[1] = 8'h0A;
        repeat (5) @(negedge clk);
        e0 = cyc + 1;
        pushRun(0, e0, 2, 2, 0, 1, 18, lastS);
        pulseStart(0);
        while (cyc < lastS + 17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdle(0, 12'd0);
        checkIdle(1, 12'd4094);
        repeat (150) @(negedge clk);
        checkIdle(0, 12'd0);

        for (int k = 0; k < 3; k++)
            check($sformatf("scoreboard_drained dut%0d", k), qSize(k), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
